// File: rtl/exa_crosb_e2s_with_vcs.sv
// ExaNet-to-AXIS receiver: steers packets into per-(prio,VC) FIFOs, drains them strict-prio / RR-per-level.
// Optional per-queue footer counters when EXA_E2S_PKT_CNT_EN is defined.

module exa_crosb_e2s_vc_fifo #(
  parameter int DEPTH = 40,
  parameter int TH    = 18,
  parameter int W     = 129
) (
  input  logic         S_ACLK,
  input  logic         S_ARESETN,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         full,
  output logic         prog_full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] cnt;
  logic          do_wr, do_rd;

  assign do_wr     = wr_en && !full;
  assign do_rd     = rd_en && !empty;
  assign empty     = (cnt == '0);
  assign full      = (cnt == CW'(DEPTH));
  assign prog_full = (cnt >= CW'(TH));
  assign rd_data   = mem[rptr];

  always_ff @(posedge S_ACLK) begin
    if (do_wr) mem[wptr] <= wr_data;
  end

  always_ff @(posedge S_ACLK or negedge S_ARESETN) begin
    if (!S_ARESETN) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_wr) wptr <= (wptr == AW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
      if (do_rd) rptr <= (rptr == AW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

module exa_crosb_e2s_with_vcs #(
  parameter int prio_num     = 2,
  parameter int vc_num       = 2,
  parameter int fifo_depth   = 40,
  parameter int prog_full_th = 18,
  localparam int NQ          = prio_num * vc_num,
  localparam int logVcPrio   = (NQ > 1) ? $clog2(NQ) : 1
) (
  input  logic                 S_ACLK,
  input  logic                 S_ARESETN,
  input  logic                 exanet_rx_header_valid,
  output logic                 exanet_rx_header_ready,
  input  logic                 exanet_rx_payload_valid,
  output logic                 exanet_rx_payload_ready,
  input  logic                 exanet_rx_footer_valid,
  output logic                 exanet_rx_footer_ready,
  input  logic [127:0]         exanet_rx_data,
  output logic                 M_AXIS_TVALID,
  input  logic                 M_AXIS_TREADY,
  output logic [127:0]         M_AXIS_TDATA,
  output logic                 M_AXIS_TLAST,
  output logic [NQ-1:0]        o_fifo_full,
  output logic                 o_bad_vc,
  output logic [logVcPrio-1:0] o_active_vc
`ifdef EXA_E2S_PKT_CNT_EN
  ,
  output logic [NQ-1:0][31:0]  o_pkt_cnt
`endif
);
  // Queue field carries one bit more than the index so out-of-range VCs decode as bad.
  localparam int HQW = logVcPrio + 1;
  localparam int PW  = (prio_num > 1) ? $clog2(prio_num) : 1;
  localparam int VW  = (vc_num > 1) ? $clog2(vc_num) : 1;

  typedef enum logic {RX_HDR, RX_BODY} rx_state_t;
  typedef enum logic {TX_IDLE, TX_PKT} tx_state_t;

  rx_state_t rx_state, rx_next;
  tx_state_t tx_state, tx_next;

  logic [HQW-1:0]       hq;
  logic                 hq_bad;
  logic [logVcPrio-1:0] hq_idx, rq, rq_next, sel;
  logic                 drop, drop_next;
  logic                 hdr_rdy, body_rdy;

  logic [NQ-1:0]        q_wr, q_rd, q_empty, q_full, q_pfull;
  logic [NQ-1:0][128:0] q_head;
  logic [128:0]         wr_word;

  logic [prio_num-1:0][VW-1:0] rr_ptr;
  logic                 found, grant, tx_vld;
  logic [logVcPrio-1:0] pick;
  logic [PW-1:0]        pick_p;
  logic [VW-1:0]        pick_v, pick_vn;
  int                   arb_v;

  assign hq     = exanet_rx_data[HQW-1:0];
  assign hq_bad = (hq >= HQW'(NQ));
  assign hq_idx = hq[logVcPrio-1:0];

  for (genvar q = 0; q < NQ; q++) begin : g_q
    exa_crosb_e2s_vc_fifo #(
      .DEPTH (fifo_depth),
      .TH    (prog_full_th),
      .W     (129)
    ) u_fifo (
      .S_ACLK    (S_ACLK),
      .S_ARESETN (S_ARESETN),
      .wr_en     (q_wr[q]),
      .wr_data   (wr_word),
      .rd_en     (q_rd[q]),
      .rd_data   (q_head[q]),
      .empty     (q_empty[q]),
      .full      (q_full[q]),
      .prog_full (q_pfull[q])
    );
  end

  assign o_fifo_full = q_pfull;

  // RX: header picks the queue, body words follow until the footer.
  always_comb begin
    rx_next   = rx_state;
    rq_next   = rq;
    drop_next = drop;
    hdr_rdy   = 1'b0;
    body_rdy  = 1'b0;
    o_bad_vc  = 1'b0;
    q_wr      = '0;
    wr_word   = {1'b0, exanet_rx_data};
    if (S_ARESETN) begin
      case (rx_state)
        RX_HDR: begin
          hdr_rdy = hq_bad || !q_pfull[hq_idx];
          if (exanet_rx_header_valid && hdr_rdy) begin
            rx_next = RX_BODY;
            rq_next = hq_idx;
            if (hq_bad) begin
              drop_next = 1'b1;
              o_bad_vc  = 1'b1;
            end else begin
              q_wr[hq_idx] = 1'b1;
            end
          end
        end
        RX_BODY: begin
          body_rdy = drop || !q_full[rq];
          if (exanet_rx_footer_valid && body_rdy) begin
            wr_word[128] = 1'b1;
            q_wr[rq]     = !drop;
            drop_next    = 1'b0;
            rx_next      = RX_HDR;
          end else if (exanet_rx_payload_valid && body_rdy) begin
            q_wr[rq] = !drop;
          end
        end
        default: rx_next = RX_HDR;
      endcase
    end
  end

  assign exanet_rx_header_ready  = hdr_rdy;
  assign exanet_rx_payload_ready = body_rdy;
  assign exanet_rx_footer_ready  = body_rdy;

  // Highest non-empty level wins; within it, search starts at that level's RR pointer.
  always_comb begin
    found  = 1'b0;
    pick   = '0;
    pick_p = '0;
    pick_v = '0;
    arb_v  = 0;
    for (int p = prio_num - 1; p >= 0; p--) begin
      for (int o = 0; o < vc_num; o++) begin
        arb_v = int'(rr_ptr[p]) + o;
        if (arb_v >= vc_num) arb_v = arb_v - vc_num;
        if (!found && !q_empty[p * vc_num + arb_v]) begin
          found  = 1'b1;
          pick   = logVcPrio'(p * vc_num + arb_v);
          pick_p = PW'(p);
          pick_v = VW'(arb_v);
        end
      end
    end
  end

  assign pick_vn = (pick_v == VW'(vc_num - 1)) ? '0 : pick_v + 1'b1;

  always_comb begin
    tx_next = tx_state;
    grant   = 1'b0;
    tx_vld  = 1'b0;
    q_rd    = '0;
    if (S_ARESETN) begin
      case (tx_state)
        TX_IDLE: begin
          if (found) begin
            grant   = 1'b1;
            tx_next = TX_PKT;
          end
        end
        TX_PKT: begin
          // Grant holds through an underflow; only TVALID drops.
          tx_vld = !q_empty[sel];
          if (tx_vld && M_AXIS_TREADY) begin
            q_rd[sel] = 1'b1;
            if (q_head[sel][128]) tx_next = TX_IDLE;
          end
        end
        default: tx_next = TX_IDLE;
      endcase
    end
  end

  assign M_AXIS_TVALID = tx_vld;
  assign M_AXIS_TDATA  = q_head[sel][127:0];
  assign M_AXIS_TLAST  = tx_vld && q_head[sel][128];
  assign o_active_vc   = sel;

  always_ff @(posedge S_ACLK or negedge S_ARESETN) begin
    if (!S_ARESETN) begin
      rx_state <= RX_HDR;
      tx_state <= TX_IDLE;
      rq       <= '0;
      drop     <= 1'b0;
      sel      <= '0;
      rr_ptr   <= '0;
    end else begin
      rx_state <= rx_next;
      tx_state <= tx_next;
      rq       <= rq_next;
      drop     <= drop_next;
      if (grant) begin
        sel            <= pick;
        rr_ptr[pick_p] <= pick_vn;
      end
    end
  end

`ifdef EXA_E2S_PKT_CNT_EN
  logic [NQ-1:0][31:0] pkt_cnt;

  for (genvar q = 0; q < NQ; q++) begin : g_cnt
    always_ff @(posedge S_ACLK or negedge S_ARESETN) begin
      if (!S_ARESETN)                     pkt_cnt[q] <= '0;
      else if (q_wr[q] && wr_word[128])   pkt_cnt[q] <= pkt_cnt[q] + 32'd1;
    end
  end

  assign o_pkt_cnt = pkt_cnt;
`endif
endmodule

// File: tb/tb_exa_crosb_e2s_with_vcs.sv
// Bench for exa_crosb_e2s_with_vcs: table of single packets plus hand sequences for arbitration, backpressure and reset.
`timescale 1ns/1ps
module tb_exa_crosb_e2s_with_vcs;
  localparam int NQ = 4;

  logic S_ACLK = 1'b0;
  logic S_ARESETN = 1'b0;
  logic hv = 1'b0, pv = 1'b0, fv = 1'b0;
  logic hr, pr, fr;
  logic [127:0] rxd = '0;
  logic tvalid, tlast;
  logic tready = 1'b0;
  logic [127:0] tdata;
  logic [NQ-1:0] fifo_full;
  logic bad_vc;
  logic [1:0] active_vc;
`ifdef EXA_E2S_PKT_CNT_EN
  logic [NQ-1:0][31:0] pkt_cnt;
`endif

  always #5 S_ACLK = ~S_ACLK;

  exa_crosb_e2s_with_vcs dut (
    .S_ACLK                  (S_ACLK),
    .S_ARESETN               (S_ARESETN),
    .exanet_rx_header_valid  (hv),
    .exanet_rx_header_ready  (hr),
    .exanet_rx_payload_valid (pv),
    .exanet_rx_payload_ready (pr),
    .exanet_rx_footer_valid  (fv),
    .exanet_rx_footer_ready  (fr),
    .exanet_rx_data          (rxd),
    .M_AXIS_TVALID           (tvalid),
    .M_AXIS_TREADY           (tready),
    .M_AXIS_TDATA            (tdata),
    .M_AXIS_TLAST            (tlast),
    .o_fifo_full             (fifo_full),
    .o_bad_vc                (bad_vc),
    .o_active_vc             (active_vc)
`ifdef EXA_E2S_PKT_CNT_EN
    ,
    .o_pkt_cnt               (pkt_cnt)
`endif
  );

  typedef struct {
    logic [127:0] d;
    logic         l;
    int           q;
  } beat_t;

  typedef struct {
    logic [2:0] qf;
    int         npay;
    logic       exp_bad;
    logic [1:0] exp_vc;
  } vec_t;

  beat_t exp_q[$];
  beat_t stage[NQ][$];
  int errors = 0;
  int checks = 0;
  int beats  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  always @(posedge S_ACLK)
    if (S_ARESETN) assert (!(pv && fv)) else $error("payload and footer valid together");

  // Output monitor: pops the scoreboard on every handshake, checks stability under stall.
  logic stall_d = 1'b0;
  logic [128:0] stall_w = '0;
  initial begin
    beat_t e;
    forever begin
      @(negedge S_ACLK);
      #2;
      if (!S_ARESETN) stall_d = 1'b0;
      else begin
        if (stall_d && tvalid) chk("tx_stable", 128'({tlast, tdata}), 128'(stall_w));
        stall_d = tvalid && !tready;
        stall_w = {tlast, tdata};
        if (tvalid && tready) begin
          beats++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected: got %0h want no beat", tdata);
          end else begin
            e = exp_q.pop_front();
            chk("tx_data", tdata, e.d);
            chk("tx_last", 128'(tlast), 128'(e.l));
            chk("tx_vc", 128'(active_vc), 128'(e.q));
          end
        end
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic rdy(input int kind);
    return (kind == 0) ? hr : ((kind == 1) ? pr : fr);
  endfunction

  task automatic put_word(input int kind, input logic [127:0] d, output logic bad);
    int n = 0;
    @(negedge S_ACLK);
    rxd = d;
    hv = (kind == 0);
    pv = (kind == 1);
    fv = (kind == 2);
    #1;
    while (!rdy(kind) && n < 400) begin
      @(negedge S_ACLK);
      #1;
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL rx_timeout: got ready=0 want ready=1 (kind %0d)", kind);
    end
    bad = bad_vc;
    @(posedge S_ACLK);
    #1;
    hv = 1'b0;
    pv = 1'b0;
    fv = 1'b0;
  endtask

  task automatic send_pkt(input logic [2:0] qf, input int npay, input bit direct, output logic bad);
    logic [127:0] d;
    logic b;
    beat_t w;
    bad = 1'b0;
    for (int i = 0; i <= npay + 1; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      if (i == 0) d[2:0] = qf;
      w.d = d;
      w.l = (i == npay + 1);
      w.q = int'(qf);
      if (qf < 3'(NQ)) begin
        if (direct) exp_q.push_back(w);
        else stage[qf[1:0]].push_back(w);
      end
      put_word((i == 0) ? 0 : ((i == npay + 1) ? 2 : 1), d, b);
      if (i == 0) bad = b;
      if (i == 1) chk("bad_vc_pulse_len", 128'(b), 128'd0);
    end
  endtask

  task automatic release_pkt(input int q);
    beat_t w;
    do begin
      w = stage[q].pop_front();
      exp_q.push_back(w);
    end while (!w.l && stage[q].size() > 0);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || tvalid) && n < 2000) begin
      @(negedge S_ACLK);
      #3;
      n++;
    end
    chk(name, 128'(exp_q.size()), 128'd0);
  endtask

  task automatic do_reset();
    @(negedge S_ACLK);
    S_ARESETN = 1'b0;
    hv = 1'b0; pv = 1'b0; fv = 1'b0;
    exp_q.delete();
    for (int q = 0; q < NQ; q++) stage[q].delete();
    repeat (2) @(negedge S_ACLK);
    S_ARESETN = 1'b1;
  endtask

  initial begin
    vec_t tbl[8];
    logic b;
    logic [127:0] d;
    beat_t w;
    int b0;

    tbl[0] = '{3'd1, 1, 1'b0, 2'd1};
    tbl[1] = '{3'd0, 0, 1'b0, 2'd0};
    tbl[2] = '{3'd2, 3, 1'b0, 2'd2};
    tbl[3] = '{3'd5, 1, 1'b1, 2'd2};
    tbl[4] = '{3'd3, 2, 1'b0, 2'd3};
    tbl[5] = '{3'd7, 0, 1'b1, 2'd3};
    tbl[6] = '{3'd4, 2, 1'b1, 2'd3};
    tbl[7] = '{3'd0, 4, 1'b0, 2'd0};

    // Reset state
    @(negedge S_ACLK);
    #1;
    chk("rst_hdr_rdy", 128'(hr), 128'd0);
    chk("rst_tvalid", 128'(tvalid), 128'd0);
    chk("rst_tlast", 128'(tlast), 128'd0);
    chk("rst_active", 128'(active_vc), 128'd0);
    S_ARESETN = 1'b1;
    #1;
    chk("idle_hdr_rdy", 128'(hr), 128'd1);
    chk("idle_body_rdy", 128'({pr, fr}), 128'd0);
    chk("idle_full", 128'(fifo_full), 128'd0);

    // Latency: 3-word packet to q1
    tready = 1'b1;
    b0 = beats;
    d = 128'hA0A0_0000_0000_0000_0000_0000_0000_0001;
    w = '{d, 1'b0, 1};
    exp_q.push_back(w);
    put_word(0, d, b);
    @(negedge S_ACLK);
    #1;
    chk("lat_k1_tvalid", 128'(tvalid), 128'd0);
    @(negedge S_ACLK);
    #1;
    chk("lat_k2_tvalid", 128'(tvalid), 128'd1);
    chk("lat_active", 128'(active_vc), 128'd1);
    d = 128'hB1B1_2222_3333_4444_5555_6666_7777_8888;
    w = '{d, 1'b0, 1};
    exp_q.push_back(w);
    put_word(1, d, b);
    d = 128'hC2C2_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
    w = '{d, 1'b1, 1};
    exp_q.push_back(w);
    put_word(2, d, b);
    wait_drain("lat_drain");
    chk("lat_beats", 128'(beats - b0), 128'd3);

    // Table of single packets
    for (int i = 0; i < 8; i++) begin
      send_pkt(tbl[i].qf, tbl[i].npay, 1'b1, b);
      chk("tbl_bad_vc", 128'(b), 128'(tbl[i].exp_bad));
      wait_drain("tbl_drain");
      repeat (3) @(negedge S_ACLK);
      #3;
      chk("tbl_tvalid_idle", 128'(tvalid), 128'd0);
      chk("tbl_active", 128'(active_vc), 128'(tbl[i].exp_vc));
      chk("tbl_full", 128'(fifo_full), 128'd0);
    end

    // Fill q3 under backpressure to the prog_full threshold
    tready = 1'b0;
    for (int i = 0; i < 19; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      if (i == 0) d[2:0] = 3'd3;
      w = '{d, (i == 18), 3};
      exp_q.push_back(w);
      put_word((i == 0) ? 0 : ((i == 18) ? 2 : 1), d, b);
      if (i == 16) chk("full_17w", 128'(fifo_full), 128'd0);
      if (i == 17) chk("full_18w", 128'(fifo_full), 128'h8);
    end
    @(negedge S_ACLK);
    d = {$urandom, $urandom, $urandom, $urandom};
    d[2:0] = 3'd3;
    rxd = d;
    hv = 1'b1;
    #1;
    chk("hdr_rdy_q3_full", 128'(hr), 128'd0);
    d[2:0] = 3'd0;
    rxd = d;
    #1;
    chk("hdr_rdy_q0", 128'(hr), 128'd1);
    w = '{d, 1'b0, 0};
    exp_q.push_back(w);
    @(posedge S_ACLK);
    #1;
    hv = 1'b0;
    d = {$urandom, $urandom, $urandom, $urandom};
    w = '{d, 1'b1, 0};
    exp_q.push_back(w);
    put_word(2, d, b);
    chk("full_active_q3", 128'(active_vc), 128'd3);
    tready = 1'b1;
    wait_drain("full_drain");
    #1;
    chk("full_cleared", 128'(fifo_full), 128'd0);

    // Arbitration: q3 holds the grant while q0,q1,q2 load
    do_reset();
    tready = 1'b0;
    send_pkt(3'd3, 1, 1'b0, b);
    send_pkt(3'd0, 1, 1'b0, b);
    send_pkt(3'd1, 0, 1'b0, b);
    send_pkt(3'd2, 2, 1'b0, b);
    release_pkt(3);
    release_pkt(2);
    release_pkt(0);
    release_pkt(1);
    tready = 1'b1;
    wait_drain("arb1_drain");

    // Next round: prio0 RR starts at q0 again and alternates
    tready = 1'b0;
    send_pkt(3'd2, 1, 1'b0, b);
    send_pkt(3'd1, 1, 1'b0, b);
    send_pkt(3'd0, 0, 1'b0, b);
    send_pkt(3'd0, 2, 1'b0, b);
    release_pkt(2);
    release_pkt(0);
    release_pkt(1);
    release_pkt(0);
    tready = 1'b1;
    wait_drain("arb2_drain");

    // Reset with RX mid-payload and TX stalled mid-packet
    d = {$urandom, $urandom, $urandom, $urandom};
    d[2:0] = 3'd1;
    w = '{d, 1'b0, 1};
    exp_q.push_back(w);
    put_word(0, d, b);
    repeat (3) @(negedge S_ACLK);
    tready = 1'b0;
    chk("rst_seq_hdr_out", 128'(exp_q.size()), 128'd0);
    for (int i = 0; i < 2; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      put_word(1, d, b);
    end
    @(negedge S_ACLK);
    rxd = {$urandom, $urandom, $urandom, $urandom};
    pv = 1'b1;
    #1;
    chk("pre_rst_tvalid", 128'(tvalid), 128'd1);
    chk("pre_rst_active", 128'(active_vc), 128'd1);
    #2;
    S_ARESETN = 1'b0;
    #1;
    chk("mid_rst_rdys", 128'({hr, pr, fr}), 128'd0);
    chk("mid_rst_tx", 128'({tvalid, tlast}), 128'd0);
    chk("mid_rst_active", 128'(active_vc), 128'd0);
    chk("mid_rst_bad_full", 128'({bad_vc, fifo_full}), 128'd0);
    pv = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge S_ACLK);
    S_ARESETN = 1'b1;
    #1;
`ifdef EXA_E2S_PKT_CNT_EN
    chk("cnt_before", 128'(pkt_cnt), 128'd0);
`endif
    tready = 1'b1;
    send_pkt(3'd2, 2, 1'b1, b);
    wait_drain("post_rst_drain");
`ifdef EXA_E2S_PKT_CNT_EN
    chk("cnt_after_q2", 128'(pkt_cnt[2]), 128'd1);
    chk("cnt_after_all", 128'(pkt_cnt), {32'd0, 32'd1, 32'd0, 32'd0});
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
